// File: rtl/shift_mix_seq.sv
// AES round stage after subbytes: ShiftRows, then iterative MixColumns over
// COLS_PER_CYCLE columns per clock. The final round skips MixColumns.
module shift_mix_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
            $error("shift_mix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    logic [127:0] work;
    logic [1:0]   col_idx;
    logic         lastf;
    logic [127:0] mix_next;
    logic [2:0]   col_end;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
        b3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Row-major packing: byte s[r][c] lives at bits [127-8*(4r+c) -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int c = 0; c < 4; c++) begin
                r[127-8*(4*row+c) -: 8] = s[127-8*(4*row+((c+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input int c);
        return {s[127-8*c -: 8], s[127-8*(4+c) -: 8],
                s[127-8*(8+c) -: 8], s[127-8*(12+c) -: 8]};
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input int c,
                                             input logic [31:0] col);
        logic [127:0] r;
        r = s;
        r[127-8*c -: 8]      = col[31:24];
        r[127-8*(4+c) -: 8]  = col[23:16];
        r[127-8*(8+c) -: 8]  = col[15:8];
        r[127-8*(12+c) -: 8] = col[7:0];
        return r;
    endfunction

    assign col_end = {1'b0, col_idx} + 3'(COLS_PER_CYCLE);

    always_comb begin
        mix_next = work;
        for (int c = 0; c < 4; c++) begin
            if (c >= int'(col_idx) && c < int'(col_idx) + COLS_PER_CYCLE) begin
                mix_next = put_col(mix_next, c, mix_column(get_col(work, c)));
            end
        end
    end

    assign state_out = work;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            work      <= '0;
            col_idx   <= '0;
            lastf     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        work     <= shift_rows(state_in);
                        lastf    <= last_round;
                        col_idx  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (last_round) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            fsm <= MIX;
                        end
                    end
                end
                MIX: begin
                    work    <= mix_next;
                    col_idx <= col_end[1:0];
                    // A final-round state never reaches MIX; lastf just forces an exit.
                    if (col_end == 3'd4 || lastf) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                        col_idx   <= '0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_mix_seq.sv
// Bench for shift_mix_seq: three instances (1, 2, 4 columns per clock) checked
// against a byte-array AES ShiftRows/MixColumns model.
module tb_shift_mix_seq;

    localparam logic [127:0] T1_IN  = 128'hd4e0b81e27bfb44111985d52aef1e530;
    localparam logic [127:0] T1_OUT = 128'h04e0482866cbf8068119d326e59a7a4c;
    localparam logic [127:0] T2_OUT = 128'hd4e0b81ebfb441275d52119830aef1e5;
    localparam logic [127:0] COL_IN  = 128'hdb000000_00130000_00005300_00000045;
    localparam logic [127:0] COL_OUT = 128'h8e000000_4d000000_a1000000_bc000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   ivld, ordy, irdy, ovld, bsy;
    logic [127:0] sin;
    logic         lastr;
    logic [127:0] sout [3];

    int errors = 0;
    int checks = 0;
    int ocnt = 0;
    logic [127:0] oq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        shift_mix_seq #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (ivld[g]),
            .in_ready   (irdy[g]),
            .state_in   (sin),
            .last_round (lastr),
            .out_valid  (ovld[g]),
            .out_ready  (ordy[g]),
            .state_out  (sout[g]),
            .busy       (bsy[g])
        );
    end

    // Output handshakes of instance 0, sampled half a cycle before the edge that takes them.
    always @(negedge clk) begin
        if (rst_n && ovld[0] && ordy[0]) begin
            ocnt++;
            oq.push_back(sout[0]);
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] x, input int k);
        int p, a;
        p = 0;
        a = int'(x);
        for (int i = 0; i < 8; i++) begin
            if (k[i]) p = p ^ a;
            a = a << 1;
            if ((a & 256) != 0) a = a ^ 'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] v, input logic last);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   acc;
        logic [127:0] res;
        int           m [4];
        m = '{2, 3, 1, 1};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = v[127-8*(4*r+c) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = s[r][(c+r)%4];
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (last) begin
                    acc = t[r][c];
                end else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++) acc = acc ^ gmul(t[k][c], m[(k-r+4)%4]);
                end
                res[127-8*(4*r+c) -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Offer one state to instance idx; optionally wait for out_valid and report
    // how many edges after the accepting edge it appeared (0 = right after it).
    task automatic accept(input int idx, input logic [127:0] data, input logic last,
                          input bit wait_out, input string tag, output int edges);
        int n;
        sin = data;
        lastr = last;
        ivld[idx] = 1'b1;
        n = 0;
        while (!irdy[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, 128'(irdy[idx]), 128'd1);
        @(posedge clk);
        #1;
        ivld[idx] = 1'b0;
        edges = 0;
        if (wait_out) begin
            while (!ovld[idx] && edges < 20) begin
                @(posedge clk);
                #1;
                edges++;
            end
            chk({tag, "_out_valid"}, 128'(ovld[idx]), 128'd1);
        end
    endtask

    initial begin
        int e, c0;
        logic [127:0] held, v;
        logic l;
        logic [127:0] expq[$];

        rst_n = 1'b0;
        ivld = '0;
        ordy = 3'b111;
        sin = '0;
        lastr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst%0d_out_valid", g), 128'(ovld[g]), 128'd0);
            chk($sformatf("rst%0d_state_out", g), sout[g], 128'd0);
            chk($sformatf("rst%0d_in_ready", g), 128'(irdy[g]), 128'd1);
            chk($sformatf("rst%0d_busy", g), 128'(bsy[g]), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // T1: FIPS-197 round-1 vector
        accept(0, T1_IN, 1'b0, 1'b1, "t1", e);
        chk("t1_latency", 128'(e), 128'd4);
        chk("t1_fips", sout[0], T1_OUT);
        chk("t1_model", sout[0], model(T1_IN, 1'b0));
        chk("t1_busy", 128'(bsy[0]), 128'd1);
        chk("t1_in_ready_low", 128'(irdy[0]), 128'd0);
        @(posedge clk);
        #1;
        chk("t1_drained", 128'(ovld[0]), 128'd0);
        chk("t1_idle_ready", 128'(irdy[0]), 128'd1);
        chk("t1_idle_busy", 128'(bsy[0]), 128'd0);

        // T2: final-round bypass
        accept(0, T1_IN, 1'b1, 1'b1, "t2", e);
        chk("t2_latency", 128'(e), 128'd0);
        chk("t2_bypass", sout[0], T2_OUT);
        chk("t2_model", sout[0], model(T1_IN, 1'b1));
        @(posedge clk);
        #1;

        // T3: backpressure with in_valid hammered during DONE
        ordy[0] = 1'b0;
        v = {$urandom, $urandom, $urandom, $urandom};
        accept(0, v, 1'b0, 1'b1, "t3", e);
        held = sout[0];
        chk("t3_model", held, model(v, 1'b0));
        for (int i = 0; i < 10; i++) begin
            ivld[0] = 1'b1;
            sin = {$urandom, $urandom, $urandom, $urandom};
            lastr = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk($sformatf("t3_hold_valid%0d", i), 128'(ovld[0]), 128'd1);
            chk($sformatf("t3_hold_ready%0d", i), 128'(irdy[0]), 128'd0);
            chk($sformatf("t3_hold_data%0d", i), sout[0], held);
        end
        ivld[0] = 1'b0;
        c0 = ocnt;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_release", 128'(ovld[0]), 128'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("t3_one_output", 128'(ocnt - c0), 128'd1);
        chk("t3_no_extra", 128'(ovld[0]), 128'd0);

        // T4: reset two cycles into MIX, then T1 again
        v = {$urandom, $urandom, $urandom, $urandom};
        accept(0, v, 1'b0, 1'b0, "t4", e);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t4_out_valid", 128'(ovld[0]), 128'd0);
        chk("t4_state_out", sout[0], 128'd0);
        chk("t4_in_ready", 128'(irdy[0]), 128'd1);
        chk("t4_busy", 128'(bsy[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(0, T1_IN, 1'b0, 1'b1, "t4_rerun", e);
        chk("t4_rerun_latency", 128'(e), 128'd4);
        chk("t4_rerun_fips", sout[0], T1_OUT);
        @(posedge clk);
        #1;

        // T5: wider column parallelism
        accept(1, T1_IN, 1'b0, 1'b1, "t5_cpc2", e);
        chk("t5_cpc2_latency", 128'(e), 128'd2);
        chk("t5_cpc2_fips", sout[1], T1_OUT);
        accept(2, T1_IN, 1'b0, 1'b1, "t5_cpc4", e);
        chk("t5_cpc4_latency", 128'(e), 128'd1);
        chk("t5_cpc4_fips", sout[2], T1_OUT);
        v = {$urandom, $urandom, $urandom, $urandom};
        accept(1, v, 1'b0, 1'b1, "t5_cpc2_rand", e);
        chk("t5_cpc2_rand", sout[1], model(v, 1'b0));
        accept(2, v, 1'b1, 1'b1, "t5_cpc4_last", e);
        chk("t5_cpc4_last", sout[2], model(v, 1'b1));
        @(posedge clk);
        #1;

        // T6: known MixColumns column, landing where ShiftRows put it
        accept(0, COL_IN, 1'b0, 1'b1, "t6_col", e);
        chk("t6_col_known", sout[0], COL_OUT);
        chk("t6_col_model", sout[0], model(COL_IN, 1'b0));
        accept(0, 128'hdb000000_13000000_53000000_45000000, 1'b0, 1'b1, "t6_col0", e);
        chk("t6_col0_model", sout[0], model(128'hdb000000_13000000_53000000_45000000, 1'b0));

        // Four back-to-back random vectors, one output each, in order
        @(posedge clk);
        #1;
        c0 = ocnt;
        oq.delete();
        for (int i = 0; i < 4; i++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            l = 1'($urandom_range(0, 1));
            expq.push_back(model(v, l));
            accept(0, v, l, 1'b1, $sformatf("t6_b2b%0d", i), e);
            chk($sformatf("t6_b2b%0d_data", i), sout[0], expq[i]);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("t6_b2b_count", 128'(ocnt - c0), 128'd4);
        for (int i = 0; i < 4; i++) begin
            held = (i < oq.size()) ? oq[i] : 'x;
            chk($sformatf("t6_b2b_order%0d", i), held, expq[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
